store_narrow_unit: RTL and testbench

- Write-side counterpart of the datapath's halfword sign-extension on the load/immediate path. Takes a 32-bit register value plus a byte address and size, narrows it to byte or halfword, and merges it into a word-addressed data memory.
- Sub-word stores use a read-modify-write sequence. Word stores are written directly.
- Also flags value narrowing that loses information: upper bits that are not a sign-extension of the stored part.
- Sits between the MEM-stage store logic and the word-wide data memory.

---
 rtl/store_narrow_unit.sv | 124 ++++++++++++
 tb/tb_store_narrow_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_narrow_unit.sv
// Narrows a 32-bit register value to byte/halfword/word and stores it into a word-wide memory.
// Sub-word stores read-modify-write; the trunc flag reports upper bits that were not a sign extension.
module store_narrow_unit #(
    parameter int ADDR_W      = 32,
    parameter int CHECK_TRUNC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err,
    output logic              trunc
);

    typedef enum logic [2:0] {IDLE, RD, MERGE, WR, ERR} state_t;

    state_t      state;
    logic [1:0]  lane;
    logic [15:0] data_lo;
    logic        is_half;
    logic        trunc_q;

    logic        illegal;
    logic        misaligned;
    logic        trunc_calc;
    logic [31:0] merged;

    assign req_ready = (state == IDLE);

    always_comb begin
        illegal    = (req_size == 2'b11);
        misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
        trunc_calc = 1'b0;
        if (CHECK_TRUNC != 0) begin
            if (req_size == 2'b00)
                trunc_calc = (req_data[31:8] != {24{req_data[7]}});
            else if (req_size == 2'b01)
                trunc_calc = (req_data[31:16] != {16{req_data[15]}});
        end
    end

    // Little-endian lane insert; bytes outside the lane keep the value just read.
    always_comb begin
        merged = mem_rdata;
        if (is_half) begin
            if (lane[1])
                merged[31:16] = data_lo;
            else
                merged[15:0] = data_lo;
        end else begin
            merged[8*lane +: 8] = data_lo[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            trunc     <= 1'b0;
            lane      <= '0;
            data_lo   <= '0;
            is_half   <= 1'b0;
            trunc_q   <= 1'b0;
        end else begin
            // Strobes and status are single-cycle pulses unless a transition raises them.
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            trunc     <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mem_addr <= req_addr[ADDR_W-1:2];
                        lane     <= req_addr[1:0];
                        data_lo  <= req_data[15:0];
                        is_half  <= (req_size == 2'b01);
                        trunc_q  <= trunc_calc;
                        if (illegal || misaligned) begin
                            state <= ERR;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (req_size == 2'b10) begin
                            state     <= WR;
                            mem_wr_en <= 1'b1;
                            mem_wdata <= req_data;
                            done      <= 1'b1;
                        end else begin
                            state     <= RD;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                RD: state <= MERGE;
                MERGE: begin
                    state     <= WR;
                    mem_wdata <= merged;
                    mem_wr_en <= 1'b1;
                    done      <= 1'b1;
                    trunc     <= trunc_q;
                end
                WR:      state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: a small word memory plus a byte-array reference model of the store.
// Directed vectors, randomized stores, reset abort and back-to-back throughput.
module tb_store_narrow_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic [29:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic        done;
    logic        err;
    logic        trunc;

    logic        load_en;
    logic [3:0]  load_idx;
    logic [31:0] load_val;
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    store_narrow_unit #(.ADDR_W(32), .CHECK_TRUNC(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .done(done), .err(err), .trunc(trunc)
    );

    // Word memory with one-cycle read latency; the bench can preload words through load_*.
    always @(posedge clk) begin
        if (load_en)
            mem[load_idx] <= load_val;
        else if (mem_wr_en)
            mem[mem_addr[3:0]] <= mem_wdata;
        if (mem_rd_en)
            mem_rdata <= mem[mem_addr[3:0]];
    end

    function automatic logic model_err(input logic [31:0] a, input logic [1:0] s);
        return (s == 2'd3) || (s == 2'd1 && (a % 2) != 0) || (s == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic logic model_trunc(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        int full;
        if (model_err(a, s)) return 1'b0;
        sb = d[7:0];
        sh = d[15:0];
        full = $signed(d);
        if (s == 2'd0) return int'(sb) != full;
        if (s == 2'd1) return int'(sh) != full;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] a,
                                                input logic [31:0] d, input logic [1:0] s);
        logic [7:0] b [4];
        int k;
        for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
        k = a % 4;
        if (s == 2'd0) begin
            b[k] = d[7:0];
        end else if (s == 2'd1) begin
            b[k]   = d[7:0];
            b[k+1] = d[15:8];
        end else begin
            for (int i = 0; i < 4; i++) b[i] = d[8*i +: 8];
        end
        return {b[3], b[2], b[1], b[0]};
    endfunction

    task automatic poke(input int idx, input logic [31:0] v);
        @(negedge clk);
        load_en  = 1'b1;
        load_idx = idx[3:0];
        load_val = v;
        @(negedge clk);
        load_en = 1'b0;
        ref_mem[idx] = v;
    endtask

    // Presents one request in an IDLE cycle and observes the unit until done or a cycle budget expires.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                            output logic ready_at_acc, output int done_cyc, output logic err_o,
                            output logic trunc_o, output int rd_cnt, output int wr_cnt,
                            output logic [31:0] wr_word, output logic [29:0] wr_addr,
                            output logic overlap);
        done_cyc = -1; err_o = 1'b0; trunc_o = 1'b0; rd_cnt = 0; wr_cnt = 0;
        wr_word = '0; wr_addr = '0; overlap = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
        #1 ready_at_acc = req_ready;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_data = $urandom; req_size = 2'($urandom);
        for (int c = 1; c <= 8 && done_cyc < 0; c++) begin
            if (c > 1) @(negedge clk);
            if (mem_rd_en) rd_cnt++;
            if (mem_wr_en) begin wr_cnt++; wr_word = mem_wdata; wr_addr = mem_addr; end
            if (mem_rd_en && mem_wr_en) overlap = 1'b1;
            if (done) begin done_cyc = c; err_o = err; trunc_o = trunc; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b1; req_addr = 32'h10; req_data = 32'h1234_5678; req_size = 2'b10;
        load_en = 1'b0; load_idx = '0; load_val = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0 || done !== 1'b0 ||
            err !== 1'b0 || trunc !== 1'b0 || mem_addr !== 30'h0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got ready=%b rd=%b wr=%b done=%b err=%b trunc=%b addr=%h wdata=%h, want 1 0 0 0 0 0 0 0",
                     req_ready, mem_rd_en, mem_wr_en, done, err, trunc, mem_addr, mem_wdata);
        end
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || mem_wr_en !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_no_accept: got done=%b wr=%b want 0 0", done, mem_wr_en);
        end
        for (int i = 0; i < 16; i++) poke(i, $urandom);
    endtask

    task automatic test_directed();
        logic [31:0] t_addr [5] = '{32'h10, 32'h16, 32'h0, 32'h3, 32'h0};
        logic [31:0] t_data [5] = '{32'hDEADBEEF, 32'h000000AB, 32'hFFFF8001, 32'h1234, 32'h55};
        logic [1:0]  t_size [5] = '{2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        logic [31:0] t_pre  [5] = '{32'h0, 32'h11223344, 32'hAAAABBBB, 32'h0, 32'h0};
        logic [31:0] t_word [5] = '{32'hDEADBEEF, 32'h11AB3344, 32'hAAAA8001, 32'h0, 32'h0};
        int          t_done [5] = '{1, 3, 3, 1, 1};
        int          t_rd   [5] = '{0, 1, 1, 0, 0};
        int          t_wr   [5] = '{1, 1, 1, 0, 0};
        logic        t_err  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        t_trn  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic rdy, e, t, ov;
        int dc, rc, wc;
        logic [31:0] ww;
        logic [29:0] wa;
        for (int i = 0; i < 5; i++) begin
            if (t_wr[i] != 0) poke(int'(t_addr[i] >> 2), t_pre[i]);
            do_store(t_addr[i], t_data[i], t_size[i], rdy, dc, e, t, rc, wc, ww, wa, ov);
            n_cmp++;
            if (dc != t_done[i] || e !== t_err[i] || t !== t_trn[i] || rc != t_rd[i] || wc != t_wr[i] || ov !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL directed_%0d_ctrl: got done_cyc=%0d err=%b trunc=%b rd=%0d wr=%0d ov=%b want %0d %b %b %0d %0d 0",
                         i, dc, e, t, rc, wc, ov, t_done[i], t_err[i], t_trn[i], t_rd[i], t_wr[i]);
            end
            if (t_wr[i] != 0) begin
                n_cmp++;
                if (ww !== t_word[i] || wa !== 30'(t_addr[i] >> 2)) begin
                    n_fail++;
                    $display("[TB] FAIL directed_%0d_write: got word=%h addr=%h want word=%h addr=%h",
                             i, ww, wa, t_word[i], 30'(t_addr[i] >> 2));
                end
                ref_mem[t_addr[i] >> 2] = t_word[i];
            end
        end
    endtask

    task automatic test_random();
        logic rdy, e, t, ov;
        int dc, rc, wc, idx;
        logic [31:0] ww, a, d, exp_word;
        logic [29:0] wa;
        logic [1:0] s;
        logic exp_err, exp_trunc;
        for (int n = 0; n < 60; n++) begin
            a = $urandom_range(0, 63);
            s = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       d = $urandom;
                1:       d = {{24{1'($urandom)}}, 8'($urandom)};
                default: d = 32'($signed(16'($urandom)));
            endcase
            idx = int'(a >> 2);
            exp_err   = model_err(a, s);
            exp_trunc = model_trunc(a, d, s);
            exp_word  = model_merge(ref_mem[idx], a, d, s);
            do_store(a, d, s, rdy, dc, e, t, rc, wc, ww, wa, ov);
            n_cmp++;
            if (rdy !== 1'b1 || e !== exp_err || t !== exp_trunc || ov !== 1'b0 ||
                dc != (exp_err ? 1 : (s == 2'd2 ? 1 : 3)) ||
                rc != ((exp_err || s == 2'd2) ? 0 : 1) || wc != (exp_err ? 0 : 1)) begin
                n_fail++;
                $display("[TB] FAIL random_%0d_ctrl a=%h d=%h s=%0d: got rdy=%b done_cyc=%0d err=%b trunc=%b rd=%0d wr=%0d ov=%b, want err=%b trunc=%b",
                         n, a, d, s, rdy, dc, e, t, rc, wc, ov, exp_err, exp_trunc);
            end
            if (!exp_err) begin
                n_cmp++;
                if (ww !== exp_word || wa !== 30'(idx)) begin
                    n_fail++;
                    $display("[TB] FAIL random_%0d_write: got word=%h addr=%h want word=%h addr=%h",
                             n, ww, wa, exp_word, 30'(idx));
                end
                ref_mem[idx] = exp_word;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic rdy, e, t, ov;
        int dc, rc, wc, wr_seen;
        logic [31:0] ww;
        logic [29:0] wa;
        poke(7, 32'hCAFE_F00D);
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h1D; req_data = 32'h0000_0077; req_size = 2'b00;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1 || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0 || done !== 1'b0 ||
            err !== 1'b0 || trunc !== 1'b0 || mem_addr !== 30'h0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_outputs: got ready=%b rd=%b wr=%b done=%b addr=%h wdata=%h, want 1 0 0 0 0 0",
                     req_ready, mem_rd_en, mem_wr_en, done, mem_addr, mem_wdata);
        end
        wr_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_wr_en) wr_seen++;
        end
        rst_n = 1'b1;
        n_cmp++;
        if (wr_seen != 0 || mem[7] !== ref_mem[7]) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_no_write: got writes=%0d word=%h want 0 %h", wr_seen, mem[7], ref_mem[7]);
        end
        do_store(32'h24, 32'h0BAD_BEEF, 2'b10, rdy, dc, e, t, rc, wc, ww, wa, ov);
        n_cmp++;
        if (rdy !== 1'b1 || dc != 1 || wc != 1 || rc != 0 || ww !== 32'h0BAD_BEEF || wa !== 30'h9) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_recover: got rdy=%b done_cyc=%0d wr=%0d rd=%0d word=%h addr=%h want 1 1 1 0 0badbeef 9",
                     rdy, dc, wc, rc, ww, wa);
        end
        ref_mem[9] = 32'h0BAD_BEEF;
    endtask

    task automatic test_back_to_back();
        logic [31:0] b_addr [3] = '{32'h20, 32'h24, 32'h2B};
        logic [31:0] b_data [3] = '{32'h0101_0101, 32'h0202_0202, 32'hFFFF_FF9C};
        logic [1:0]  b_size [3] = '{2'b10, 2'b10, 2'b00};
        int exp_acc [3] = '{0, 2, 4};
        int exp_wr  [3] = '{1, 3, 7};
        int acc [$];
        int wrs [$];
        int rds [$];
        int r;
        logic exp_ready;
        logic [31:0] last_word, exp_byte_word;
        exp_byte_word = model_merge(ref_mem[10], b_addr[2], b_data[2], b_size[2]);
        last_word = '0;
        r = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (r < 3) begin
                req_valid = 1'b1; req_addr = b_addr[r]; req_data = b_data[r]; req_size = b_size[r];
            end else begin
                req_valid = 1'b0;
            end
            #1;
            exp_ready = (c == 0 || c == 2 || c == 4 || c >= 8);
            n_cmp++;
            if (req_ready !== exp_ready) begin
                n_fail++;
                $display("[TB] FAIL b2b_ready_cycle_%0d: got %b want %b", c, req_ready, exp_ready);
            end
            if (mem_wr_en) begin wrs.push_back(c); last_word = mem_wdata; end
            if (mem_rd_en) rds.push_back(c);
            if (req_valid && req_ready) begin acc.push_back(c); r++; end
        end
        req_valid = 1'b0;
        n_cmp++;
        if (acc.size() != 3 || wrs.size() != 3 || rds.size() != 1) begin
            n_fail++;
            $display("[TB] FAIL b2b_counts: got accepts=%0d writes=%0d reads=%0d want 3 3 1",
                     acc.size(), wrs.size(), rds.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (acc[i] != exp_acc[i] || wrs[i] != exp_wr[i]) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_timing_%0d: got accept=%0d write=%0d want %0d %0d",
                             i, acc[i], wrs[i], exp_acc[i], exp_wr[i]);
                end
            end
            n_cmp++;
            if (rds[0] != 5 || last_word !== exp_byte_word) begin
                n_fail++;
                $display("[TB] FAIL b2b_byte_store: got read_cycle=%0d word=%h want 5 %h", rds[0], last_word, exp_byte_word);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
